// File: rtl/int_arbiter_pkg.sv
// Shared register map, widths and bus decode helper for the external-interrupt arbiter.
// Defining INT_ARB_SYNC_EN puts a two-flop synchronizer in front of every source's edge detector.
package int_arbiter_pkg;

  localparam int ID_W           = 4;
  localparam int PRIO_W_DEFAULT = 3;

  localparam logic [7:0] INT_ARB_PRIO_BASE = 8'h00;
  localparam logic [7:0] INT_ARB_PENDING   = 8'h40;
  localparam logic [7:0] INT_ARB_ENABLE    = 8'h44;
  localparam logic [7:0] INT_ARB_THRESHOLD = 8'h48;
  localparam logic [7:0] INT_ARB_CLAIM     = 8'h4C;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PRIO,
    REG_PENDING,
    REG_ENABLE,
    REG_THRESHOLD,
    REG_CLAIM
  } reg_sel_e;

  // Word address in, register selection out; PRIO slots beyond the source count are unmapped.
  function automatic reg_sel_e decode_reg(input logic [5:0] word, input int num_src);
    reg_sel_e sel;
    sel = REG_NONE;
    if (int'(word - INT_ARB_PRIO_BASE[7:2]) < num_src)
      sel = REG_PRIO;
    else if (word == INT_ARB_PENDING[7:2])
      sel = REG_PENDING;
    else if (word == INT_ARB_ENABLE[7:2])
      sel = REG_ENABLE;
    else if (word == INT_ARB_THRESHOLD[7:2])
      sel = REG_THRESHOLD;
    else if (word == INT_ARB_CLAIM[7:2])
      sel = REG_CLAIM;
    return sel;
  endfunction

endpackage

// File: rtl/int_src_gateway.sv
// Per-source gateway: optional synchronizer (INT_ARB_SYNC_EN), rising-edge detect,
// and the pending / in-service flops driven by claim and complete strobes.
module int_src_gateway
  import int_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic inservice_o
);

  logic src_s;
  logic src_d;
  logic rise;

`ifdef INT_ARB_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = src_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_d <= 1'b0;
    else        src_d <= src_s;
  end

  assign rise = src_s & ~src_d;

  // A claim beats a coincident edge, and an edge seen while in service is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_o   <= 1'b0;
      inservice_o <= 1'b0;
    end else begin
      if (claim_i)
        pending_o <= 1'b0;
      else if (rise && !inservice_o)
        pending_o <= 1'b1;

      if (claim_i)
        inservice_o <= 1'b1;
      else if (complete_i)
        inservice_o <= 1'b0;
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Memory-mapped external-interrupt arbiter: register file, priority selection and claim/complete.
// Build with INT_ARB_SYNC_EN defined when src_i is asynchronous to clk.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = PRIO_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o
);

  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  threshold;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] inservice;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] complete_vec;

  logic [ID_W-1:0]    best_id;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;

  logic [5:0]         word;
  reg_sel_e           sel;
  logic               wr_en;
  logic               rd_en;
  logic               claim_fire;
  logic               complete_fire;
  logic [31:0]        read_data;
  logic               unused_bits;

  assign word          = addr_i[7:2];
  assign sel           = decode_reg(word, NUM_SRC);
  assign wr_en         = req_i & we_i;
  assign rd_en         = req_i & ~we_i;
  assign claim_fire    = rd_en && (sel == REG_CLAIM) && (best_id != '0);
  assign complete_fire = wr_en && (sel == REG_CLAIM);
  assign unused_bits   = ^{wdata_i, addr_i[1:0]};

  // Complete IDs of 0 or above NUM_SRC match no gateway; the gateway ignores idle sources.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign claim_vec[g]    = claim_fire && (best_id == ID_W'(g + 1));
    assign complete_vec[g] = complete_fire && (wdata_i[ID_W-1:0] == ID_W'(g + 1));

    int_src_gateway u_gateway (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_i       (src_i[g]),
      .claim_i     (claim_vec[g]),
      .complete_i  (complete_vec[g]),
      .pending_o   (pending[g]),
      .inservice_o (inservice[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
      enable    <= '0;
      threshold <= '0;
    end else if (wr_en) begin
      case (sel)
        REG_PRIO: begin
          for (int i = 0; i < NUM_SRC; i++)
            if (word == 6'(i)) prio[i] <= wdata_i[PRIO_W-1:0];
        end
        REG_ENABLE:    enable    <= wdata_i[NUM_SRC-1:0];
        REG_THRESHOLD: threshold <= wdata_i[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Strictly-greater compare while scanning upward keeps the lowest ID on a priority tie.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > win_prio)) begin
        win_id   = ID_W'(i + 1);
        win_prio = prio[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_id <= '0;
      irq_o   <= 1'b0;
    end else begin
      best_id <= win_id;
      irq_o   <= (win_id != '0) && (win_prio > threshold);
    end
  end

  assign irq_id_o = best_id;

  always_comb begin
    read_data = '0;
    case (sel)
      REG_PRIO: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (word == 6'(i)) read_data = 32'(prio[i]);
      end
      REG_PENDING:   read_data = 32'(pending);
      REG_ENABLE:    read_data = 32'(enable);
      REG_THRESHOLD: read_data = 32'(threshold);
      REG_CLAIM:     read_data = 32'(best_id);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= rd_en ? read_data : '0;
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Scoreboard bench for int_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_int_arbiter;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 3;
`ifdef INT_ARB_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic [NUM_SRC-1:0] src_i = '0;
  logic               req_i = 1'b0;
  logic               we_i  = 1'b0;
  logic [7:0]         addr_i = '0;
  logic [31:0]        wdata_i = '0;
  logic [31:0]        rdata_o;
  logic               ack_o;
  logic               irq_o;
  logic [3:0]         irq_id_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;
  logic        req_q = 1'b0;

  int                 m_prio [NUM_SRC];
  logic [NUM_SRC-1:0] m_pend;
  logic [NUM_SRC-1:0] m_insvc;
  logic [NUM_SRC-1:0] m_en;
  logic [NUM_SRC-1:0] m_src;
  int                 m_thr;

  always #5 clk = ~clk;

  int_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_i    (src_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .ack_o    (ack_o),
    .irq_o    (irq_o),
    .irq_id_o (irq_id_o)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_SRC; i++) m_prio[i] = 0;
    m_pend  = '0;
    m_insvc = '0;
    m_en    = '0;
    m_src   = '0;
    m_thr   = 0;
  endfunction

  function automatic bit model_cand(input int i);
    return m_pend[i] && m_en[i] && (m_prio[i] != 0);
  endfunction

  // Highest priority among candidates first, then the lowest ID holding that priority.
  function automatic int model_winner();
    int top = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (model_cand(i) && m_prio[i] > top) top = m_prio[i];
    if (top == 0) return 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (model_cand(i) && m_prio[i] == top) return i + 1;
    return 0;
  endfunction

  function automatic bit model_irq();
    int w = model_winner();
    return (w != 0) && (m_prio[w-1] > m_thr);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [7:0] wa = a & 8'hFC;
    if (wa < 8'h40) return (int'(wa) / 4 < NUM_SRC) ? 32'(m_prio[int'(wa) / 4]) : 32'd0;
    case (wa)
      8'h40:   return 32'(m_pend);
      8'h44:   return 32'(m_en);
      8'h48:   return 32'(m_thr);
      8'h4C:   return 32'(model_winner());
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] wa = a & 8'hFC;
    int id;
    if (wa < 8'h40) begin
      if (int'(wa) / 4 < NUM_SRC) m_prio[int'(wa) / 4] = int'(d % (1 << PRIO_W));
    end else if (wa == 8'h44) begin
      m_en = d[NUM_SRC-1:0];
    end else if (wa == 8'h48) begin
      m_thr = int'(d % (1 << PRIO_W));
    end else if (wa == 8'h4C) begin
      id = int'(d % 16);
      if (id >= 1 && id <= NUM_SRC && m_insvc[id-1]) m_insvc[id-1] = 1'b0;
    end
  endfunction

  function automatic void model_claim();
    int w = model_winner();
    if (w != 0) begin
      m_pend[w-1]  = 1'b0;
      m_insvc[w-1] = 1'b1;
    end
  endfunction

  function automatic void model_src(input logic [NUM_SRC-1:0] v);
    for (int i = 0; i < NUM_SRC; i++)
      if (v[i] && !m_src[i] && !m_insvc[i]) m_pend[i] = 1'b1;
    m_src = v;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    exp_q.push_back(32'd0);
    name_q.push_back("write_rdata");
    model_write(a, d);
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input string nm);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = $urandom;
    exp_q.push_back(model_read(a));
    name_q.push_back(nm);
    if ((a & 8'hFC) == 8'h4C) model_claim();
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [NUM_SRC-1:0] v);
    @(negedge clk);
    src_i = v;
    model_src(v);
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk);
    check_output({tag, "_irq"}, 32'(irq_o), 32'(model_irq()));
    check_output({tag, "_id"}, 32'(irq_id_o), 32'(model_winner()));
  endtask

  always @(posedge clk) req_q <= req_i;

  // Monitor: every acknowledge retires the oldest expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_o || req_q) check_output("ack_timing", 32'(ack_o), 32'(req_q));
      if (ack_o) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          check_output(mon_name, rdata_o, mon_exp);
        end
      end else begin
        check_output("rdata_idle", rdata_o, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]         a;
    logic [NUM_SRC-1:0] v;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_output("reset_irq", 32'(irq_o), 32'd0);
    check_output("reset_id", 32'(irq_id_o), 32'd0);
    check_output("reset_ack", 32'(ack_o), 32'd0);

    $display("[TB] basic claim/complete");
    bus_write(8'h08, 32'd5);
    bus_write(8'h44, 32'h04);
    bus_write(8'h48, 32'd0);
    @(negedge clk);
    src_i = 8'h04;
    model_src(8'h04);
    repeat (LAT) @(negedge clk);
    check_output("irq_early", 32'(irq_o), 32'd0);
    check_irq("irq_latency");
    bus_read(8'h4C, "claim_basic");
    check_irq("after_claim");
    bus_write(8'h4C, 32'd3);
    apply_stimulus(8'h00);
    apply_stimulus(8'h04);
    bus_read(8'h40, "pending_reaccept");
    check_irq("reaccept");
    bus_read(8'h4C, "claim_again");
    bus_write(8'h4C, 32'd3);
    apply_stimulus(8'h00);

    $display("[TB] priority and tie");
    bus_write(8'h04, 32'd4);
    bus_write(8'h14, 32'd6);
    bus_write(8'h18, 32'd6);
    bus_write(8'h44, 32'h62);
    apply_stimulus(8'h62);
    for (int i = 0; i < 4; i++) begin
      bus_read(8'h4C, "claim_order");
      check_irq("order");
    end
    bus_write(8'h4C, 32'd6);
    bus_write(8'h4C, 32'd7);
    bus_write(8'h4C, 32'd2);
    apply_stimulus(8'h00);

    $display("[TB] threshold");
    bus_write(8'h44, 32'h01);
    bus_write(8'h00, 32'd2);
    bus_write(8'h48, 32'd2);
    apply_stimulus(8'h01);
    check_irq("thr_block");
    bus_write(8'h48, 32'd1);
    check_output("thr_hold", 32'(irq_o), 32'd0);
    check_irq("thr_open");
    bus_read(8'h4C, "claim_thr");
    bus_write(8'h4C, 32'd1);
    apply_stimulus(8'h00);
    bus_write(8'h48, 32'd0);

    $display("[TB] edge during service and invalid complete");
    bus_write(8'h0C, 32'd3);
    bus_write(8'h44, 32'h08);
    apply_stimulus(8'h08);
    bus_read(8'h4C, "claim_four");
    apply_stimulus(8'h00);
    apply_stimulus(8'h08);
    bus_write(8'h4C, 32'd0);
    bus_write(8'h4C, 32'd9);
    bus_write(8'h4C, 32'd5);
    apply_stimulus(8'h00);
    apply_stimulus(8'h08);
    bus_read(8'h40, "pending_in_service");
    bus_write(8'h4C, 32'd4);
    bus_read(8'h40, "pending_after_complete");
    apply_stimulus(8'h00);
    apply_stimulus(8'h08);
    bus_read(8'h40, "pending_new_edge");
    check_irq("after_service");
    bus_read(8'h4C, "claim_four_again");
    bus_write(8'h4C, 32'd4);
    bus_read(8'h20, "unmapped_prio");
    bus_read(8'h50, "unmapped_high");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: begin
          v = m_src ^ NUM_SRC'(1 << $urandom_range(0, NUM_SRC - 1));
          apply_stimulus(v);
        end
        1: begin
          a = 8'($urandom_range(0, 63) << 2) | 8'($urandom_range(0, 3));
          bus_write(a, $urandom);
        end
        2: bus_write(8'h44, $urandom);
        3: bus_write(8'h48, $urandom);
        4: begin
          a = 8'($urandom_range(0, 63) << 2) | 8'($urandom_range(0, 3));
          if ((a & 8'hFC) == 8'h4C) a = 8'h40;
          bus_read(a, "rand_read");
        end
        5: bus_read(8'h4C | 8'($urandom_range(0, 3)), "rand_claim");
        default: bus_write(8'h4C, 32'($urandom_range(0, 15)));
      endcase
      check_irq("rand");
    end

    $display("[TB] reset mid-service");
    bus_write(8'h44, 32'hFF);
    for (int i = 0; i < NUM_SRC; i++) bus_write(8'(i * 4), 32'($urandom_range(1, 7)));
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    bus_read(8'h4C, "claim_before_reset");
    apply_stimulus(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("rst_mid_irq", 32'(irq_o), 32'd0);
    check_output("rst_mid_id", 32'(irq_id_o), 32'd0);
    check_output("rst_mid_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) bus_read(8'(i * 4), "rst_prio");
    bus_read(8'h40, "rst_pending");
    bus_read(8'h44, "rst_enable");
    bus_read(8'h48, "rst_threshold");
    bus_read(8'h4C, "rst_claim");
    check_irq("rst_final");

    repeat (3) @(negedge clk);
    check_output("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
